packed_word_serializer: RTL and testbench
=========================================

# packed_word_serializer

Downstream stage for the 32-bit packed word register (2 slices × 2 elements × 8-bit bytes). The block accepts one packed word per valid/ready handshake and emits its bytes one per cycle on a byte stream, in fixed element order. A per-byte keep mask lets it skip bytes. The output side is fully registered, so the block also acts as the timing break between the word register and the byte-wide link.

## Interface
Parameters:
- `BYTE_W`, default 8: width of one element byte. Fixed at 8 for this revision.
- `N_BYTES`, default 4: bytes per word (2 slices × 2 elements). Fixed at 4.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in_valid`, in, 1: word offer.
- `in_ready`, out, 1: word accepted when `in_valid && in_ready`.
- `in_data`, in, 32: packed word, `word_t` ([1:0][1:0][7:0]).
- `in_keep`, in, 4: bit k enables flat byte k, where k = slice*2 + element.
- `out_valid`, out, 1: byte available.
- `out_ready`, in, 1: byte consumed when `out_valid && out_ready`.
- `out_data`, out, 8: byte value.
- `out_idx`, out, 2: flat index k of the byte (bit1 = slice, bit0 = element).
- `out_last`, out, 1: final kept byte of the current word.
- `busy`, out, 1: a word is held (state SEND).

## Operation
- States:
  - IDLE: no word held.
  - SEND: word held; remaining-mask `rem` is non-zero.
- Accepting a word:
  - IDLE: `in_ready`=1.
  - On accept with `in_keep != 0`: latch `in_data`, set `rem = in_keep`, go to SEND.
  - On accept with `in_keep == 0`: word is consumed and dropped. Stay IDLE; no output.
- SEND output:
  - `out_valid`=1.
  - `out_idx` = lowest set bit of `rem`.
  - `out_data` = latched word[`out_idx`[1]][`out_idx`[0]].
  - `out_last` = 1 when `rem` has exactly one bit set.
- Byte handshake (`out_valid && out_ready`): clear that bit of `rem`.
  - If `rem` becomes 0 and no word is accepted the same cycle: go to IDLE.
- Back-to-back: in SEND, `in_ready = out_last && out_ready`.
  - A word accepted on the last-byte handshake cycle loads directly. SEND continues with the new `rem`, with no bubble.
  - If that new word has keep=0, it is dropped and the state goes to IDLE.
- Byte order within a word is always ascending k: [0][0], [0][1], [1][0], [1][1].
- Bytes with keep=0 are never presented.
- `out_data`, `out_idx` and `out_last` are held stable while `out_valid && !out_ready`.
- `in_data` and `in_keep` are sampled only on the accept cycle.
- Reset (any time, including mid-word):
  - Held word is discarded; state = IDLE.
  - `out_valid`=0, `out_data`=0, `out_idx`=0, `out_last`=0, `busy`=0.
  - `in_ready`=0 while `rst_n`=0; `in_ready`=1 from the first clock edge after deassertion.

## Timing
- Latency: word accepted at edge N → first byte valid after edge N (visible cycle N+1).
- Throughput: one byte per cycle when `out_ready`=1. A word with p kept bytes occupies exactly p output cycles.
- Sustained full-keep stream: 4 cycles/word, no idle cycles between words.
- `in_ready` has a combinational path from `out_ready` and registered state only. There is no combinational path from `in_valid` to `in_ready`.
- All other outputs are registered or decoded from registered state only (no input-to-output combinational path).

## Structure
- Package `packed_array_pkg` holds:
  - `byte_t` = logic [7:0]
  - `word_t` = logic [1:0][1:0][7:0]
  - `keep_t` = logic [3:0]
  - `N_BYTES` = 4
  - state enum `ser_state_e` {IDLE, SEND}
- Sub-module `keep_first_set`: combinational lowest-set-bit finder on a 4-bit mask. Outputs `idx`[1:0], `onehot`[3:0] and `single` (exactly one bit set). It is reused by the upstream word packer.

## Test plan
- Full word: `in_data`=32'h01234567, keep=4'hF, `out_ready`=1 → bytes 67,45,23,01 with idx 0,1,2,3 on four consecutive cycles; `out_last` only on 01; `in_ready` high on the 01 cycle.
- Sparse keep: `in_data`=32'hAABBCCDD, keep=4'b1010 → bytes CC (idx 1), AA (idx 3, last); then `busy`=0.
- Back-to-back with backpressure: words 32'h11223344/F and 32'h55667788/F; hold `out_ready`=0 for 3 cycles on idx 2 → `out_data`=22 stable throughout; exactly 8 bytes in order 44,33,22,11,88,77,66,55; no bubble between 11 and 88 when `out_ready`=1.
- Keep zero: word with keep=4'h0 offered in IDLE → accepted in 1 cycle, no `out_valid`. Same word offered on a last-byte cycle → accepted, state returns to IDLE.
- Reset mid-word: reset asserted after the first byte of 32'hDEADBEEF/F → all outputs 0 immediately; after release, no residual bytes; next word 32'h0000_00A5/4'h1 → single byte A5, idx 0, last.
- Random soak: 10k random words, keeps and `out_ready`, checked against a scoreboard model of byte/idx/last order; no handshake-protocol violations.

Source files
------------

// File: rtl/packed_array_pkg.sv
// Shared types for the packed word datapath: bytes, 2x2 packed words,
// per-byte keep masks and the serializer state encoding.
package packed_array_pkg;

  localparam int N_BYTES = 4;

  typedef logic [7:0]             byte_t;
  typedef logic [1:0][1:0][7:0]   word_t;
  typedef logic [N_BYTES-1:0]     keep_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/keep_first_set.sv
// Lowest-set-bit finder on a 4-bit keep mask. Purely combinational so the
// packer and the serializer can both decode their pending masks in-cycle.
module keep_first_set
  import packed_array_pkg::*;
(
  input  logic [3:0] mask,
  output logic [1:0] idx,
  output logic [3:0] onehot,
  output logic       single
);

  // Isolate the lowest set bit, encode it, and flag a mask with one bit left.
  always_comb begin
    onehot = mask & (~mask + 4'd1);
    idx    = 2'd0;
    if (onehot[1]) idx = 2'd1;
    if (onehot[2]) idx = 2'd2;
    if (onehot[3]) idx = 2'd3;
    single = (mask != 4'd0) && ((mask & (mask - 4'd1)) == 4'd0);
  end

endmodule

// File: rtl/packed_word_serializer.sv
// Takes one packed 2x2 byte word per handshake and streams its kept bytes
// out in ascending flat index order. All byte-side outputs decode from
// registered state, so this block is the timing break to the byte link.
module packed_word_serializer
  import packed_array_pkg::*;
#(
  parameter int BYTE_W  = 8,
  parameter int N_BYTES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_BYTES*BYTE_W-1:0] in_data,
  input  logic [N_BYTES-1:0]        in_keep,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BYTE_W-1:0]         out_data,
  output logic [1:0]                out_idx,
  output logic                      out_last,
  output logic                      busy
);

  ser_state_e state;
  keep_t      rem;
  word_t      word_p1;
  logic       ready_en;

  logic [1:0] cur_idx;
  logic [3:0] cur_onehot;
  logic       cur_single;
  logic       accept;
  logic       byte_hs;

  keep_first_set u_first (
    .mask   (rem),
    .idx    (cur_idx),
    .onehot (cur_onehot),
    .single (cur_single)
  );

  // Output decode from registered state only; in_ready sees out_ready but
  // never in_valid, so the upstream handshake has no combinational loop.
  always_comb begin
    out_valid = (state == SEND);
    busy      = (state == SEND);
    out_idx   = cur_idx;
    out_last  = (state == SEND) && cur_single;
    out_data  = (state == SEND) ? word_p1[cur_idx[1]][cur_idx[0]] : '0;
    in_ready  = ready_en && ((state == IDLE) || (cur_single && out_ready));
    accept    = in_valid && in_ready;
    byte_hs   = (state == SEND) && out_ready;
  end

  // Control FSM: a new word (even on the last-byte cycle) replaces the
  // remaining mask; otherwise each byte handshake retires one mask bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rem      <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        rem   <= in_keep;
        state <= (in_keep != '0) ? SEND : IDLE;
      end else if (byte_hs) begin
        rem <= rem & ~cur_onehot;
        if (cur_single) state <= IDLE;
      end
    end
  end

  // Word holding register: data only, loaded when a non-empty word lands.
  always_ff @(posedge clk) begin
    if (accept && (in_keep != '0)) word_p1 <= in_data;
  end

endmodule

// File: tb/tb_packed_word_serializer.sv
// Scoreboard bench for packed_word_serializer: the driver pushes the
// expected byte sequence on each accepted word; the monitor pops and
// compares on every byte handshake.
module tb_packed_word_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [3:0]  in_keep = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rmode = 0;          // 0: out_ready=1, 1: random, 2: manual
  int acc_cycles = 0;

  logic [10:0] exp_q[$];  // {data, idx, last}
  int          hs_cyc[$];
  logic [7:0]  hs_dat[$];

  logic        stall_pend = 1'b0;
  logic [7:0]  prev_data;
  logic [1:0]  prev_idx;
  logic        prev_last;

  packed_word_serializer #(.BYTE_W(8), .N_BYTES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_keep   (in_keep),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // out_ready driver for the non-manual modes.
  initial forever begin
    @(posedge clk);
    #1;
    if (rmode == 0) out_ready = 1'b1;
    else if (rmode == 1) out_ready = ($urandom_range(3) != 0);
  end

  // Monitor: compare every byte handshake against the scoreboard, and check
  // that a stalled byte stays put until it is taken.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_data", {24'd0, out_data}, {24'd0, prev_data});
        chk("hold_idx", {30'd0, out_idx}, {30'd0, prev_idx});
        chk("hold_last", {31'd0, out_last}, {31'd0, prev_last});
      end
      if (out_valid && out_ready) begin
        stall_pend = 1'b0;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_byte: got %0h idx %0d, scoreboard empty", out_data, out_idx);
        end else begin
          logic [10:0] e;
          e = exp_q.pop_front();
          chk("byte_data", {24'd0, out_data}, {24'd0, e[10:3]});
          chk("byte_idx", {30'd0, out_idx}, {30'd0, e[2:1]});
          chk("byte_last", {31'd0, out_last}, {31'd0, e[0]});
        end
        chk("in_ready_on_hs", {31'd0, in_ready}, {31'd0, out_last});
        hs_cyc.push_back(cyc);
        hs_dat.push_back(out_data);
      end else if (out_valid) begin
        stall_pend = 1'b1;
        prev_data  = out_data;
        prev_idx   = out_idx;
        prev_last  = out_last;
      end
    end
  end

  // Offer one word, wait for acceptance, and load its expected bytes.
  task automatic send_word(input logic [31:0] d, input logic [3:0] k);
    int   waitc;
    logic r;
    waitc = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_keep  = k;
    do begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      waitc++;
    end while (!r && waitc < 200);
    acc_cycles = waitc;
    if (!r) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: word %0h not accepted in %0d cycles", d, waitc);
    end else begin
      for (int j = 0; j < 4; j++) begin
        if (k[j]) begin
          logic lst;
          lst = ((k >> (j + 1)) == 4'd0);
          exp_q.push_back({d[8*j +: 8], j[1:0], lst});
        end
      end
    end
    #1;
    in_valid = 1'b0;
    in_data  = '0;
    in_keep  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rel_in_ready_pre", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("rel_in_ready_post", {31'd0, in_ready}, 32'd1);

    // Full word, continuous ready
    hs_cyc.delete(); hs_dat.delete();
    send_word(32'h01234567, 4'hF);
    idle(6);
    chk("full_count", hs_cyc.size(), 32'd4);
    if (hs_cyc.size() == 4) chk("full_consecutive", hs_cyc[3] - hs_cyc[0], 32'd3);

    // Sparse keep
    send_word(32'hAABBCCDD, 4'b1010);
    repeat (3) @(negedge clk);
    chk("sparse_busy_after", {31'd0, busy}, 32'd0);
    idle(2);

    // Back-to-back with backpressure on idx 2
    rmode = 2;
    out_ready = 1'b1;
    hs_cyc.delete(); hs_dat.delete();
    fork
      begin
        send_word(32'h11223344, 4'hF);
        send_word(32'h55667788, 4'hF);
      end
      begin
        int t;
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!(out_valid && out_idx == 2'd1) && t < 50);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("bp_data_22", {24'd0, out_data}, 32'h22);
          chk("bp_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(8);
    rmode = 0;
    chk("bp_count", hs_cyc.size(), 32'd8);
    if (hs_cyc.size() == 8) begin
      chk("bp_b3", {24'd0, hs_dat[3]}, 32'h11);
      chk("bp_b4", {24'd0, hs_dat[4]}, 32'h88);
      chk("bp_no_bubble", hs_cyc[4] - hs_cyc[3], 32'd1);
    end

    // Keep zero in IDLE
    send_word(32'h9999_9999, 4'h0);
    chk("k0_accept_cycles", acc_cycles, 32'd1);
    @(negedge clk);
    chk("k0_no_valid", {31'd0, out_valid}, 32'd0);
    chk("k0_busy", {31'd0, busy}, 32'd0);
    idle(1);

    // Keep zero on a last-byte cycle
    send_word(32'hCAFEF00D, 4'hF);
    send_word(32'h12345678, 4'h0);
    @(negedge clk);
    chk("k0_last_idle", {31'd0, busy}, 32'd0);
    idle(2);

    // Reset mid-word
    send_word(32'hDEADBEEF, 4'hF);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_data", {24'd0, out_data}, 32'd0);
    chk("mid_rst_idx", {30'd0, out_idx}, 32'd0);
    chk("mid_rst_last", {31'd0, out_last}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    hs_cyc.delete(); hs_dat.delete();
    send_word(32'h0000_00A5, 4'h1);
    idle(5);
    chk("post_rst_count", hs_cyc.size(), 32'd1);
    chk("post_rst_empty", exp_q.size(), 32'd0);

    // Random soak
    rmode = 1;
    for (int i = 0; i < 10000; i++) begin
      send_word($urandom, 4'($urandom_range(15)));
    end
    rmode = 0;
    idle(10);
    chk("soak_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
